// File: rtl/cpu_din_sched.sv
// Z80 data-in scheduler: picks ROM, RAM, input port or interrupt vector, stretches the cycle
// with WAIT and holds the byte until the read ends. Define INTACK_VEC_EN for the int_vec port.
module cpu_din_sched #(
  parameter logic [15:0] ROM_TOP   = 16'h0FFF,
  parameter logic [7:0]  PORT_ADDR = 8'h00,
  parameter int          ROM_WAIT  = 2,
  parameter int          RAM_WAIT  = 0,
  parameter int          PORT_WAIT = 1
) (
  input  logic        pll0_100MHz,
  input  logic        n_reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_m1_n,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  ram_data,
  input  logic [7:0]  port_data,
`ifdef INTACK_VEC_EN
  input  logic [7:0]  int_vec,
`endif
  output logic        rom_sel,
  output logic        ram_sel,
  output logic        port_sel,
  output logic        cpu_wait_n,
  output logic [7:0]  cpu_din
);

  typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_WAIT, ST_DRIVE, ST_HOLD} state_t;
  typedef enum logic [1:0] {REQ_MEM, REQ_IO, REQ_INTACK} req_t;
  typedef enum logic [2:0] {SRC_ROM, SRC_RAM, SRC_PORT, SRC_FF, SRC_VEC} src_t;

  localparam logic [3:0] ROM_W  = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W  = 4'(RAM_WAIT);
  localparam logic [3:0] PORT_W = 4'(PORT_WAIT);

  // Strobe order in the synchronizer vectors: {mreq_n, iorq_n, rd_n, m1_n}; reset to inactive.
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge pll0_100MHz or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_m1_n};
      sync2_q <= sync1_q;
    end
  end

  logic mreq_n_s, iorq_n_s, rd_n_s, m1_n_s;
  assign {mreq_n_s, iorq_n_s, rd_n_s, m1_n_s} = sync2_q;

  logic mem_rd, io_rd, intack;
  assign mem_rd = !mreq_n_s && !rd_n_s;
  assign io_rd  = !iorq_n_s && !rd_n_s && m1_n_s;
  assign intack = !iorq_n_s && !m1_n_s;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  din_q, din_d;

  always_ff @(posedge pll0_100MHz or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      req_q   <= REQ_MEM;
      addr_q  <= 16'h0000;
      cnt_q   <= 4'd0;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
    end
  end

  // Source is decoded only from the latched address, so later bus changes cannot move it.
  src_t src;
  always_comb begin
    src = SRC_FF;
    case (req_q)
      REQ_MEM: src = (addr_q <= ROM_TOP) ? SRC_ROM : SRC_RAM;
      REQ_IO:  src = (addr_q[7:0] == PORT_ADDR) ? SRC_PORT : SRC_FF;
`ifdef INTACK_VEC_EN
      REQ_INTACK: src = SRC_VEC;
`endif
      default: src = SRC_FF;
    endcase
  end

  logic [3:0] src_wait;
  logic [7:0] src_data;
  always_comb begin
    src_wait = 4'd0;
    src_data = 8'hFF;
    case (src)
      SRC_ROM: begin
        src_wait = ROM_W;
        src_data = rom_data;
      end
      SRC_RAM: begin
        src_wait = RAM_W;
        src_data = ram_data;
      end
      SRC_PORT: begin
        src_wait = PORT_W;
        src_data = port_data;
      end
`ifdef INTACK_VEC_EN
      SRC_VEC: src_data = int_vec;
`endif
      default: begin
        src_wait = 4'd0;
        src_data = 8'hFF;
      end
    endcase
  end

  logic req_live, bus_released;
  always_comb begin
    req_live = 1'b0;
    case (req_q)
      REQ_MEM:    req_live = mem_rd;
      REQ_IO:     req_live = io_rd;
      REQ_INTACK: req_live = intack;
      default:    req_live = 1'b0;
    endcase
  end

  assign bus_released = rd_n_s && ((req_q == REQ_MEM) ? mreq_n_s : iorq_n_s);

  // Any strobe loss before HOLD aborts straight back to IDLE with the bus cleared.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: begin
        din_d = 8'h00;
        cnt_d = 4'd0;
        if (mem_rd || io_rd || intack) begin
          addr_d  = cpu_addr;
          req_d   = mem_rd ? REQ_MEM : (io_rd ? REQ_IO : REQ_INTACK);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          din_d   = 8'h00;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = src_wait;
          state_d = (src_wait != 4'd0) ? ST_WAIT : ST_DRIVE;
        end
      end
      ST_WAIT: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          din_d   = 8'h00;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          din_d   = 8'h00;
        end else begin
          din_d   = src_data;
          state_d = ST_HOLD;
        end
        cnt_d = 4'd0;
      end
      ST_HOLD: begin
        if (bus_released) begin
          state_d = ST_IDLE;
          din_d   = 8'h00;
        end
      end
      default: begin
        state_d = ST_IDLE;
        din_d   = 8'h00;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset clears WAIT and selects at once.
  logic busy, stretching;
  assign busy       = (state_q != ST_IDLE);
  assign stretching = (state_q == ST_DECODE) || (state_q == ST_WAIT) || (state_q == ST_DRIVE);

  assign rom_sel    = busy && (src == SRC_ROM);
  assign ram_sel    = busy && (src == SRC_RAM);
  assign port_sel   = busy && (src == SRC_PORT);
  assign cpu_wait_n = !(stretching && (src_wait != 4'd0));
  assign cpu_din    = din_q;

endmodule
